// File: rtl/operand_encoder_if.sv
// Descriptor-in / byte-out handshake bundle for operand_encoder.
// master drives descriptors and out_ready; slave is the encoder.
interface operand_encoder_if;
  logic               req_valid;
  logic               req_ready;
  logic [7:0]         req_opcode;
  logic               req_w;
  logic [3:0]         req_reg;
  logic               req_is_mem;
  logic               req_rip;
  logic               req_has_base;
  logic [3:0]         req_base;
  logic               req_has_idx;
  logic [3:0]         req_idx;
  logic [1:0]         req_scale;
  logic signed [31:0] req_disp;
  logic [63:0]        req_imm;
  logic [3:0]         req_imm_bytes;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_byte;
  logic               out_last;
  logic               err;

  modport master (
    output req_valid, req_opcode, req_w, req_reg, req_is_mem, req_rip, req_has_base,
           req_base, req_has_idx, req_idx, req_scale, req_disp, req_imm, req_imm_bytes,
           out_ready,
    input  req_ready, out_valid, out_byte, out_last, err
  );

  modport slave (
    input  req_valid, req_opcode, req_w, req_reg, req_is_mem, req_rip, req_has_base,
           req_base, req_has_idx, req_idx, req_scale, req_disp, req_imm, req_imm_bytes,
           out_ready,
    output req_ready, out_valid, out_byte, out_last, err
  );
endinterface

// File: rtl/operand_encoder.sv
// Packs an x86-64 operand descriptor into REX/opcode/ModRM/SIB/disp/imm bytes, one per cycle.
// Define ENC_DISP8_COMPRESS_EN to use disp8 (mod=01) whenever the displacement fits in a byte.
module operand_encoder #(
  parameter int IMM_MAX_BYTES = 8
) (
  input  logic             clk,
  input  logic             reset,
  operand_encoder_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_REX, S_OPC, S_MODRM, S_SIB, S_DISP, S_IMM} state_t;

  function automatic logic [7:0] pick_byte(input logic [63:0] v, input logic [2:0] i);
    return v[{i, 3'b000} +: 8];
  endfunction

`ifdef ENC_DISP8_COMPRESS_EN
  function automatic logic fits_disp8(input logic signed [31:0] d);
    return (d >= -32'sd128) && (d <= 32'sd127);
  endfunction
`endif

  state_t      state_q, nxt_state;
  logic [2:0]  cnt_q, nxt_cnt;
  logic        ready_q, vld_q, last_q, err_q;
  logic [7:0]  byte_q, nxt_byte;
  logic        nxt_last;

  logic        rex_x, rex_b, need_rex, need_sib, imm_ok, reject, accept;
  logic [7:0]  rex_byte, modrm_byte, sib_byte;
  logic [1:0]  md;
  logic [2:0]  rm, dlen;

  logic [7:0]  opc_q, modrm_q, sib_q;
  logic        need_sib_q;
  logic [31:0] disp_q;
  logic [2:0]  dlen_q;
  logic [63:0] imm_q;
  logic [3:0]  ilen_q;

  // Descriptor decode: everything about the instruction shape is settled here, at acceptance.
  always_comb begin
    rex_x    = bus.req_has_idx & bus.req_idx[3] & bus.req_is_mem & ~bus.req_rip;
    rex_b    = bus.req_base[3] & (~bus.req_is_mem | (~bus.req_rip & bus.req_has_base));
    rex_byte = {4'b0100, bus.req_w, bus.req_reg[3], rex_x, rex_b};
    need_rex = |rex_byte[3:0];
    need_sib = bus.req_is_mem & ~bus.req_rip &
               (bus.req_has_idx | ~bus.req_has_base | (bus.req_base[2:0] == 3'b100));
    sib_byte = {bus.req_scale,
                bus.req_has_idx  ? bus.req_idx[2:0]  : 3'b100,
                bus.req_has_base ? bus.req_base[2:0] : 3'b101};
    md   = 2'b11;
    rm   = bus.req_base[2:0];
    dlen = 3'd0;
    if (bus.req_is_mem) begin
      if (bus.req_rip) begin
        md   = 2'b00;
        rm   = 3'b101;
        dlen = 3'd4;
      end else begin
        rm = need_sib ? 3'b100 : bus.req_base[2:0];
        if (!bus.req_has_base) begin
          md   = 2'b00;
          dlen = 3'd4;
        end else if (bus.req_disp == 32'sd0 && bus.req_base[2:0] != 3'b101) begin
          md   = 2'b00;
          dlen = 3'd0;
        end else begin
`ifdef ENC_DISP8_COMPRESS_EN
          if (fits_disp8(bus.req_disp)) begin
            md   = 2'b01;
            dlen = 3'd1;
          end else begin
            md   = 2'b10;
            dlen = 3'd4;
          end
`else
          md   = 2'b10;
          dlen = 3'd4;
`endif
        end
      end
    end
    modrm_byte = {md, bus.req_reg[2:0], rm};
    case (bus.req_imm_bytes)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd8: imm_ok = (int'(bus.req_imm_bytes) <= IMM_MAX_BYTES);
      default:                      imm_ok = 1'b0;
    endcase
    reject = (bus.req_has_idx && bus.req_idx == 4'b0100) || !imm_ok;
    accept = (state_q == S_IDLE) && ready_q && bus.req_valid;
  end

  always_ff @(posedge clk) begin
    if (accept && !reject) begin
      opc_q      <= bus.req_opcode;
      modrm_q    <= modrm_byte;
      sib_q      <= sib_byte;
      need_sib_q <= need_sib;
      disp_q     <= bus.req_disp;
      dlen_q     <= dlen;
      imm_q      <= bus.req_imm;
      ilen_q     <= bus.req_imm_bytes;
    end
  end

  // Sequencer: successor state, byte and last flag after the current byte is taken.
  always_comb begin
    state_t tail_disp, tail_imm;
    tail_imm  = (ilen_q != 4'd0) ? S_IMM : S_IDLE;
    tail_disp = (dlen_q != 3'd0) ? S_DISP : tail_imm;
    nxt_state = S_IDLE;
    nxt_cnt   = 3'd0;
    case (state_q)
      S_REX:   nxt_state = S_OPC;
      S_OPC:   nxt_state = S_MODRM;
      S_MODRM: nxt_state = need_sib_q ? S_SIB : tail_disp;
      S_SIB:   nxt_state = tail_disp;
      S_DISP:
        if (cnt_q == dlen_q - 3'd1) nxt_state = tail_imm;
        else begin
          nxt_state = S_DISP;
          nxt_cnt   = cnt_q + 3'd1;
        end
      S_IMM:
        if ({1'b0, cnt_q} == ilen_q - 4'd1) nxt_state = S_IDLE;
        else begin
          nxt_state = S_IMM;
          nxt_cnt   = cnt_q + 3'd1;
        end
      default: nxt_state = S_IDLE;
    endcase
    nxt_byte = 8'h00;
    nxt_last = 1'b0;
    case (nxt_state)
      S_OPC:   nxt_byte = opc_q;
      S_MODRM: begin
        nxt_byte = modrm_q;
        nxt_last = !need_sib_q && dlen_q == 3'd0 && ilen_q == 4'd0;
      end
      S_SIB: begin
        nxt_byte = sib_q;
        nxt_last = dlen_q == 3'd0 && ilen_q == 4'd0;
      end
      S_DISP: begin
        nxt_byte = pick_byte({32'd0, disp_q}, nxt_cnt);
        nxt_last = (nxt_cnt == dlen_q - 3'd1) && ilen_q == 4'd0;
      end
      S_IMM: begin
        nxt_byte = pick_byte(imm_q, nxt_cnt);
        nxt_last = {1'b0, nxt_cnt} == ilen_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        ready_q <= 1'b1;
        if (accept) begin
          if (reject) begin
            err_q <= 1'b1;
          end else begin
            state_q <= need_rex ? S_REX : S_OPC;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
            vld_q   <= 1'b1;
            byte_q  <= need_rex ? rex_byte : bus.req_opcode;
            last_q  <= 1'b0;
          end
        end
      end else if (vld_q && bus.out_ready) begin
        state_q <= nxt_state;
        cnt_q   <= nxt_cnt;
        if (nxt_state == S_IDLE) begin
          ready_q <= 1'b1;
          vld_q   <= 1'b0;
          byte_q  <= 8'h00;
          last_q  <= 1'b0;
        end else begin
          byte_q <= nxt_byte;
          last_q <= nxt_last;
        end
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.out_valid = vld_q;
  assign bus.out_byte  = byte_q;
  assign bus.out_last  = last_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_operand_encoder.sv
// Directed vector bench for operand_encoder: table of descriptors with expected byte streams,
// plus reset-state and mid-stream reset sequences.
module tb_operand_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_encoder_if bus ();

  operand_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0]   opc;
    logic         w;
    logic [3:0]   rg;
    logic         mem;
    logic         rip;
    logic         hb;
    logic [3:0]   base;
    logic         hi;
    logic [3:0]   idx;
    logic [1:0]   sc;
    logic [31:0]  disp;
    logic [63:0]  imm;
    logic [3:0]   ib;
    logic         stall;
    logic         err;
    int           len;
    logic [127:0] exp;   // bytes in emission order, right-aligned
  } vec_t;

  vec_t vt [16];
  int   nv;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ebyte(input vec_t v, input int i);
    logic [127:0] e;
    e = v.exp;
    return e[8*(v.len-1-i) +: 8];
  endfunction

  task automatic drive(input vec_t v);
    bus.req_opcode    = v.opc;
    bus.req_w         = v.w;
    bus.req_reg       = v.rg;
    bus.req_is_mem    = v.mem;
    bus.req_rip       = v.rip;
    bus.req_has_base  = v.hb;
    bus.req_base      = v.base;
    bus.req_has_idx   = v.hi;
    bus.req_idx       = v.idx;
    bus.req_scale     = v.sc;
    bus.req_disp      = v.disp;
    bus.req_imm       = v.imm;
    bus.req_imm_bytes = v.ib;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc;
    int n;
    bit done;
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d ready_before", id), 128'(bus.req_ready), 128'(1));
    drive(v);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = v.stall ? (cyc % 2 == 0) : 1'b1;
      if (cyc == 0) chk($sformatf("v%0d err", id), 128'(bus.err), 128'(v.err));
      if (v.err) begin
        chk($sformatf("v%0d no_bytes", id), 128'(bus.out_valid), 128'(0));
        if (cyc == 2) begin
          chk($sformatf("v%0d ready_after_err", id), 128'(bus.req_ready), 128'(1));
          done = 1'b1;
        end
      end else if (bus.out_valid) begin
        if (n < v.len) begin
          chk($sformatf("v%0d byte%0d", id, n), 128'(bus.out_byte), 128'(ebyte(v, n)));
          if (bus.out_ready) begin
            chk($sformatf("v%0d last%0d", id, n), 128'(bus.out_last), 128'(n == v.len - 1));
            n++;
            if (bus.out_last) done = 1'b1;
          end
        end else begin
          chk($sformatf("v%0d overrun", id), 128'(n + 1), 128'(v.len));
          done = 1'b1;
        end
      end
      cyc++;
    end
    if (!v.err) begin
      chk($sformatf("v%0d count", id), 128'(n), 128'(v.len));
      @(negedge clk);
      chk($sformatf("v%0d ready_after", id), 128'(bus.req_ready), 128'(1));
      chk($sformatf("v%0d idle_valid", id), 128'(bus.out_valid), 128'(0));
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    // opc w rg mem rip hb base hi idx sc disp imm ib stall err len exp
    vt[0]  = '{8'h89, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 2'd0, 32'h0, 64'h0, 4'd0,
               1'b0, 1'b0, 3, 128'h4889C3};
`ifdef ENC_DISP8_COMPRESS_EN
    vt[1]  = '{8'h8B, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 4'd0, 2'd0, 32'd8, 64'h0, 4'd0,
               1'b0, 1'b0, 5, 128'h498B4C2408};
    vt[4]  = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 2'd0, 32'h0, 64'h0, 4'd0,
               1'b0, 1'b0, 3, 128'h8B4500};
    vt[9]  = '{8'h80, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 2'd0, 32'hFFFFFFF0, 64'h7F, 4'd1,
               1'b0, 1'b0, 4, 128'h8053F07F};
    vt[13] = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 2'd0, 32'd127, 64'h0, 4'd0,
               1'b0, 1'b0, 3, 128'h8B467F};
    vt[15] = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 2'd0, 32'hFFFFFF80, 64'h0, 4'd0,
               1'b0, 1'b0, 3, 128'h8B4680};
`else
    vt[1]  = '{8'h8B, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 4'd0, 2'd0, 32'd8, 64'h0, 4'd0,
               1'b0, 1'b0, 8, 128'h498B8C2408000000};
    vt[4]  = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 2'd0, 32'h0, 64'h0, 4'd0,
               1'b0, 1'b0, 6, 128'h8B8500000000};
    vt[9]  = '{8'h80, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 2'd0, 32'hFFFFFFF0, 64'h7F, 4'd1,
               1'b0, 1'b0, 7, 128'h8093F0FFFFFF7F};
    vt[13] = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 2'd0, 32'd127, 64'h0, 4'd0,
               1'b0, 1'b0, 6, 128'h8B867F000000};
    vt[15] = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 2'd0, 32'hFFFFFF80, 64'h0, 4'd0,
               1'b0, 1'b0, 6, 128'h8B8680FFFFFF};
`endif
    vt[2]  = '{8'h8B, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 32'h12345678, 64'h0, 4'd0,
               1'b0, 1'b0, 6, 128'h8B1578563412};
    vt[3]  = '{8'hC7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 2'd0, 32'h0, 64'hDEADBEEF, 4'd4,
               1'b1, 1'b0, 6, 128'hC7C0EFBEADDE};
    vt[5]  = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd4, 2'd0, 32'h0, 64'h0, 4'd0,
               1'b0, 1'b1, 0, 128'h0};
    vt[6]  = '{8'hC7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 2'd0, 32'h0, 64'h1, 4'd3,
               1'b0, 1'b1, 0, 128'h0};
    vt[7]  = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1, 2'd2, 32'h200, 64'h0, 4'd0,
               1'b0, 1'b0, 7, 128'h8B848800020000};
    vt[8]  = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 2'd3, 32'hFFFFFFFC, 64'h0, 4'd0,
               1'b0, 1'b0, 8, 128'h428B04CDFCFFFFFF};
    vt[10] = '{8'hC7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 2'd0, 32'h0, 64'h1122334455667788, 4'd8,
               1'b1, 1'b0, 11, 128'h49C7C78877665544332211};
    vt[11] = '{8'hC7, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 2'd0, 32'h1000, 64'h0102030405060708, 4'd8,
               1'b0, 1'b0, 16, 128'h48C78424001000000807060504030201};
    vt[12] = '{8'h01, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 2'd0, 32'h0, 64'h0, 4'd0,
               1'b0, 1'b0, 3, 128'h4401CA};
    vt[14] = '{8'h8B, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 4'd0, 2'd0, 32'd128, 64'h0, 4'd0,
               1'b0, 1'b0, 6, 128'h8B8680000000};
    nv = 16;

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(vt[0]);
    repeat (3) @(negedge clk);
    chk("rst out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst req_ready", 128'(bus.req_ready), 128'(0));
    chk("rst err", 128'(bus.err), 128'(0));
    chk("rst out_byte", 128'(bus.out_byte), 128'(0));
    chk("rst out_last", 128'(bus.out_last), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("release req_ready", 128'(bus.req_ready), 128'(1));

    for (int i = 0; i < nv; i++) run_vec(vt[i], i);

    // Reset in the middle of a stalled stream
    drive(vt[3]);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall hold valid", 128'(bus.out_valid), 128'(1));
    chk("stall hold byte", 128'(bus.out_byte), 128'(8'hC7));
    #2 reset = 1'b1;
    #1;
    chk("midrst out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst req_ready", 128'(bus.req_ready), 128'(0));
    chk("midrst out_last", 128'(bus.out_last), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post midrst ready", 128'(bus.req_ready), 128'(1));
    chk("post midrst valid", 128'(bus.out_valid), 128'(0));
    run_vec(vt[0], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
